tube_scan_driver: RTL and testbench

- Display back-end that consumes the 32-bit value held by the digital-tube MMIO register (`tubeNum`) and drives the board's three seven-segment groups.
- Time-multiplexes two 4-digit tube groups in lockstep and drives one static single-digit tube.
- Latches the displayed value only at frame boundaries so digits never tear mid-scan.
- Sits between the tube register block and the FPGA pins.

---
 rtl/tube_scan_driver.sv | 119 +++++++++++
 tb/tb_tube_scan_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tube_scan_driver.sv
// Seven-segment scan driver for the digital-tube MMIO value.
// Two 4-digit groups are scanned in lockstep and one single-digit tube is static.
// The displayed value is latched only at frame wrap or on refresh, so digits never tear.
module tube_scan_driver #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] num,
  input  logic [3:0]  aux,
  input  logic        refresh,
  input  logic        blank,
  output logic [7:0]  digital_tube0,
  output logic [3:0]  digital_tube_sel0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam int unsigned CntW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [7:0] SegXor   = {8{SEG_ACTIVE_LOW}};
  localparam logic [7:0] SegOff   = SegXor;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [31:0]     frame_q, frame_d;
  logic [3:0]      frame_aux_q, frame_aux_d;
  logic            blank_q;
  logic            tick;
  logic            load;

  // Active-high segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
  function automatic logic [7:0] seg_pattern(input logic [3:0] d);
    logic [7:0] p;
    case (d)
      4'h0: p = 8'h3F;
      4'h1: p = 8'h06;
      4'h2: p = 8'h5B;
      4'h3: p = 8'h4F;
      4'h4: p = 8'h66;
      4'h5: p = 8'h6D;
      4'h6: p = 8'h7D;
      4'h7: p = 8'h07;
      4'h8: p = 8'h7F;
      4'h9: p = 8'h6F;
      4'hA: p = 8'h77;
      4'hB: p = 8'h7C;
      4'hC: p = 8'h39;
      4'hD: p = 8'h5E;
      4'hE: p = 8'h79;
      default: p = 8'h71;
    endcase
    return p;
  endfunction

  // Prescaler, digit index and frame-buffer next-state.
  always_comb begin
    tick        = (cnt_q == CntMax);
    cnt_d       = tick ? '0 : cnt_q + CntW'(1);
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    // Wrap and refresh in the same cycle collapse into one load of the current inputs.
    load        = refresh || (tick && (idx_q == 2'd3));
    frame_d     = load ? num : frame_q;
    frame_aux_d = load ? aux : frame_aux_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      frame_q     <= 32'd0;
      frame_aux_q <= 4'd0;
      blank_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      frame_aux_q <= frame_aux_d;
      blank_q     <= blank;
    end
  end

  // Output decode from registers only; no input reaches the pins combinationally.
  always_comb begin
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] sel;
    dig0 = 4'd0;
    dig1 = 4'd0;
    case (idx_q)
      2'd0: begin dig0 = frame_q[3:0];   dig1 = frame_q[19:16]; end
      2'd1: begin dig0 = frame_q[7:4];   dig1 = frame_q[23:20]; end
      2'd2: begin dig0 = frame_q[11:8];  dig1 = frame_q[27:24]; end
      default: begin dig0 = frame_q[15:12]; dig1 = frame_q[31:28]; end
    endcase
    sel = 4'b0001 << idx_q;

    if (blank_q) begin
      digital_tube0     = SegOff;
      digital_tube1     = SegOff;
      digital_tube2     = SegOff;
      digital_tube_sel0 = 4'b0000;
      digital_tube_sel1 = 4'b0000;
      digital_tube_sel2 = 1'b0;
    end else begin
      digital_tube0     = seg_pattern(dig0) ^ SegXor;
      digital_tube1     = seg_pattern(dig1) ^ SegXor;
      digital_tube2     = seg_pattern(frame_aux_q) ^ SegXor;
      digital_tube_sel0 = sel;
      digital_tube_sel1 = sel;
      digital_tube_sel2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_tube_scan_driver.sv
// Scoreboard bench for tube_scan_driver (SCAN_DIV=4, active-low segments).
// The driver updates a cycle-count reference model and queues the expected pins;
// a negedge monitor pops and compares against the DUT.
module tb_tube_scan_driver;

  localparam int unsigned SD    = 4;
  localparam int unsigned Frame = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] num = 32'd0;
  logic [3:0]  aux = 4'd0;
  logic        refresh = 1'b0;
  logic        blank = 1'b0;
  logic [7:0]  digital_tube0, digital_tube1, digital_tube2;
  logic [3:0]  digital_tube_sel0, digital_tube_sel1;
  logic        digital_tube_sel2;

  tube_scan_driver #(
    .SCAN_DIV      (SD),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .num              (num),
    .aux              (aux),
    .refresh          (refresh),
    .blank            (blank),
    .digital_tube0    (digital_tube0),
    .digital_tube_sel0(digital_tube_sel0),
    .digital_tube1    (digital_tube1),
    .digital_tube_sel1(digital_tube_sel1),
    .digital_tube2    (digital_tube2),
    .digital_tube_sel2(digital_tube_sel2)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset, latched frame, latched blank.
  int unsigned m_t;
  logic [31:0] m_frame;
  logic [3:0]  m_aux;
  logic        m_blank;

  logic [32:0] exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [7:0] seg_al(input logic [3:0] d);
    return ~seg_tab[d];
  endfunction

  // Expected pins packed as {tube0, sel0, tube1, sel1, tube2, sel2}.
  function automatic logic [32:0] model_out();
    int unsigned i;
    logic [3:0] s;
    i = (m_t / SD) % 4;
    s = 4'd0;
    s[i] = 1'b1;
    if (m_blank) return {8'hFF, 4'b0000, 8'hFF, 4'b0000, 8'hFF, 1'b0};
    return {seg_al(m_frame[4*i +: 4]), s, seg_al(m_frame[16 + 4*i +: 4]), s,
            seg_al(m_aux), 1'b1};
  endfunction

  // Drive one cycle of inputs, advance the model across the coming edge, queue the result.
  task automatic step(input logic r, input logic [31:0] n, input logic [3:0] a,
                      input logic rf, input logic b);
    @(negedge clk);
    #1;
    reset = r; num = n; aux = a; refresh = rf; blank = b;
    if (r) begin
      m_t = 0; m_frame = 32'd0; m_aux = 4'd0; m_blank = 1'b0;
    end else begin
      if (rf || (m_t % Frame == Frame - 1)) begin
        m_frame = n;
        m_aux   = a;
      end
      m_blank = b;
      m_t++;
    end
    exp_q.push_back(model_out());
  endtask

  // Hold current inputs (refresh low) until the model reaches the given frame phase.
  task automatic run_to_phase(input int unsigned ph);
    for (int k = 0; k < int'(Frame) && (m_t % Frame) != ph; k++)
      step(1'b0, num, aux, 1'b0, blank);
  endtask

  // Monitor: compare every queued expectation against the pins.
  always @(negedge clk) begin
    logic [32:0] got, want;
    cyc++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {digital_tube0, digital_tube_sel0, digital_tube1, digital_tube_sel1,
              digital_tube2, digital_tube_sel2};
      checks++;
      if (got === want) passed++;
      else $display("FAIL pins cycle %0d: got %h required %h", cyc, got, want);
    end
  end

  initial begin
    m_t = 0; m_frame = 32'd0; m_aux = 4'd0; m_blank = 1'b0;
    // Reset and idle defaults.
    step(1'b1, 32'd0, 4'd0, 1'b0, 1'b0);
    step(1'b1, 32'd0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 32'h012345F0, 4'hA, 1'b0, 1'b0);
    // Scan order and first wrap load.
    for (int k = 0; k < 20; k++) step(1'b0, 32'h012345F0, 4'hA, 1'b0, 1'b0);
    // Tear-free: change num while idx=1.
    run_to_phase(SD);
    for (int k = 0; k < 24; k++) step(1'b0, 32'hFFFF_FFFF, 4'h3, 1'b0, 1'b0);
    // Refresh mid-frame at idx=0.
    run_to_phase(1);
    step(1'b0, 32'h0000_0007, 4'h5, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 32'h1111_2222, 4'h5, 1'b0, 1'b0);
    // Refresh coinciding with the wrap tick.
    run_to_phase(Frame - 1);
    step(1'b0, 32'h89AB_CDEF, 4'hE, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    // Blank across several digit slots, then release.
    for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    // Reset at idx=2.
    run_to_phase(2 * SD + 1);
    step(1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 32'h5A5A_5A5A, 4'h7, 1'b0, 1'b0);
    // Randomized traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(63) == 0), $urandom, 4'($urandom),
           ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d left required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
